freq_meter: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 24 ++
 rtl/freq_meter_sig_sync_edge.sv | 37 +++
 rtl/freq_meter.sv | 108 ++++++++++
 tb/tb_freq_meter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the gated frequency meter.
package freq_meter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int GATE_CYCLES_DEF = 50_000_000;
    localparam int MAX_COUNT_DEF   = 999_999;

    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 1;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_meter_sig_sync_edge.sv
// Synchronises an asynchronous input into sys_clk and flags its rising edges.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic edge_now
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delayed_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge sys_clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sig_in;
                end
            end else begin : g_chain
                always_ff @(posedge sys_clk or negedge rst_n) begin
                    if (!rst_n) sync_reg[gi] <= 1'b0;
                    else        sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) delayed_reg <= 1'b0;
        else        delayed_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign edge_now = sync_reg[SYNC_STAGES-1] & ~delayed_reg;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter publishing a saturated count per window.
// Optional FREQ_METER_HOLD_EN adds a hold input that freezes the published result.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int DATA_W      = 20,
    parameter int MAX_COUNT   = MAX_COUNT_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic              hold,
`endif
    output logic [DATA_W-1:0] bin_data,
    output logic              data_valid,
    output logic              overflow
);

    localparam int GATE_W = clog2(GATE_CYCLES);
    localparam int CNT_W  = clog2(MAX_COUNT + 2);
    localparam int INIT_W = clog2(SYNC_STAGES + 1);

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(MAX_COUNT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

    state_t              state_reg;
    logic [INIT_W-1:0]   init_cnt_reg;
    logic [GATE_W-1:0]   gate_cnt_reg;
    logic [CNT_W-1:0]    edge_cnt_reg;
    logic [DATA_W-1:0]   bin_data_reg;
    logic                data_valid_reg;
    logic                overflow_reg;

    logic                edge_now;
    logic                update_en;
    logic                total_ovf;
    logic [CNT_W-1:0]    total_bin;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .edge_now (edge_now)
    );

`ifdef FREQ_METER_HOLD_EN
    assign update_en = ~hold;
`else
    assign update_en = 1'b1;
`endif

    // The edge arriving in the terminal cycle still belongs to the closing window.
    assign total_ovf = (edge_cnt_reg == CNT_SAT) || ((edge_cnt_reg == CNT_MAX) && edge_now);
    assign total_bin = total_ovf ? CNT_MAX : (edge_cnt_reg + CNT_W'(edge_now));

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_INIT;
            init_cnt_reg   <= '0;
            gate_cnt_reg   <= '0;
            edge_cnt_reg   <= '0;
            bin_data_reg   <= '0;
            data_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            data_valid_reg <= 1'b0;
            case (state_reg)
                ST_INIT: begin
                    if (init_cnt_reg == INIT_LAST) begin
                        state_reg    <= ST_RUN;
                        gate_cnt_reg <= '0;
                        edge_cnt_reg <= '0;
                    end else begin
                        init_cnt_reg <= init_cnt_reg + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (gate_cnt_reg == GATE_LAST) begin
                        gate_cnt_reg <= '0;
                        edge_cnt_reg <= '0;
                        if (update_en) begin
                            bin_data_reg   <= DATA_W'(total_bin);
                            overflow_reg   <= total_ovf;
                            data_valid_reg <= 1'b1;
                        end
                    end else begin
                        gate_cnt_reg <= gate_cnt_reg + 1'b1;
                        if (edge_now && (edge_cnt_reg != CNT_SAT))
                            edge_cnt_reg <= edge_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign bin_data   = bin_data_reg;
    assign data_valid = data_valid_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter with a 100-cycle gate window.
module tb_freq_meter;

    logic        clk;
    logic        rst_n;
    logic        sig_a, sig_b;
    logic [19:0] bin_a, bin_b;
    logic        valid_a, valid_b;
    logic        ovf_a, ovf_b;
`ifdef FREQ_METER_HOLD_EN
    logic        hold_a;
`endif

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int half_a = 0, ph_a = 0;
    int half_b = 0, ph_b = 0;

    freq_meter #(.GATE_CYCLES(100)) dut_a (
        .sys_clk    (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_a),
`ifdef FREQ_METER_HOLD_EN
        .hold       (hold_a),
`endif
        .bin_data   (bin_a),
        .data_valid (valid_a),
        .overflow   (ovf_a)
    );

    freq_meter #(.GATE_CYCLES(100), .MAX_COUNT(30)) dut_b (
        .sys_clk    (clk),
        .rst_n      (rst_n),
        .sig_in     (sig_b),
`ifdef FREQ_METER_HOLD_EN
        .hold       (1'b0),
`endif
        .bin_data   (bin_b),
        .data_valid (valid_b),
        .overflow   (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Square-wave generators: toggle every half_x negedges; half_x==0 leaves the pin to the main sequence.
    initial begin
        forever begin
            @(negedge clk);
            if (half_a != 0) begin
                ph_a++;
                if (ph_a >= half_a) begin ph_a = 0; sig_a = ~sig_a; end
            end
            if (half_b != 0) begin
                ph_b++;
                if (ph_b >= half_b) begin ph_b = 0; sig_b = ~sig_b; end
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    task automatic wait_valid(input int sel, input int budget, output int at);
        at = -1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((sel == 0) ? valid_a : valid_b) begin
                at = cyc;
                break;
            end
        end
    endtask

    typedef struct {
        string name;
        int    sel;
        int    half;
        logic  lvl;
        int    exp_bin;
        logic  exp_ovf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int at, prev, rel, v;

        vecs[0] = '{"a_period10",  0, 5,  1'b0, 10, 1'b0};
        vecs[1] = '{"a_period2",   0, 1,  1'b0, 50, 1'b0};
        vecs[2] = '{"a_period4",   0, 2,  1'b0, 25, 1'b0};
        vecs[3] = '{"a_period100", 0, 50, 1'b0, 1,  1'b0};
        vecs[4] = '{"a_const1",    0, 0,  1'b1, 0,  1'b0};
        vecs[5] = '{"a_const0",    0, 0,  1'b0, 0,  1'b0};
        vecs[6] = '{"b_sat50",     1, 1,  1'b0, 30, 1'b1};
        vecs[7] = '{"b_recover10", 1, 5,  1'b0, 10, 1'b0};
        vecs[8] = '{"b_period4",   1, 2,  1'b0, 25, 1'b0};
        vecs[9] = '{"b_period50",  1, 25, 1'b0, 2,  1'b0};

        rst_n = 1'b0;
        sig_a = 1'b0;
        sig_b = 1'b0;
        half_a = 10;
`ifdef FREQ_METER_HOLD_EN
        hold_a = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_bin_a", int'(bin_a), 0);
        check("reset_valid_a", int'(valid_a), 0);
        check("reset_ovf_a", int'(ovf_a), 0);
        check("reset_bin_b", int'(bin_b), 0);

        // First window after release, sig_in period 20
        rst_n = 1'b1;
        rel = cyc;
        wait_valid(0, 200, at);
        check("first_valid_latency", at - rel, 103);
        check("first_bin", int'(bin_a), 5);
        check("first_ovf", int'(ovf_a), 0);
        @(negedge clk);
        check("valid_one_cycle", int'(valid_a), 0);
        check("bin_holds", int'(bin_a), 5);
        prev = at;
        wait_valid(0, 200, at);
        check("second_interval", at - prev, 100);
        check("second_bin", int'(bin_a), 5);

        for (int i = 0; i < 10; i++) begin
            if (vecs[i].sel == 0) begin
                half_a = vecs[i].half; ph_a = 0;
                if (vecs[i].half == 0) sig_a = vecs[i].lvl;
            end else begin
                half_b = vecs[i].half; ph_b = 0;
                if (vecs[i].half == 0) sig_b = vecs[i].lvl;
            end
            wait_valid(vecs[i].sel, 200, prev);
            wait_valid(vecs[i].sel, 200, at);
            check({vecs[i].name, "_interval"}, at - prev, 100);
            if (vecs[i].sel == 0) begin
                check({vecs[i].name, "_bin"}, int'(bin_a), vecs[i].exp_bin);
                check({vecs[i].name, "_ovf"}, int'(ovf_a), int'(vecs[i].exp_ovf));
            end else begin
                check({vecs[i].name, "_bin"}, int'(bin_b), vecs[i].exp_bin);
                check({vecs[i].name, "_ovf"}, int'(ovf_b), int'(vecs[i].exp_ovf));
            end
        end

        // Single rising edge landing in the terminal cycle
        half_a = 0;
        sig_a = 1'b0;
        wait_valid(0, 200, v);
        while (cyc < v + 97) @(negedge clk);
        sig_a = 1'b1;
        wait_valid(0, 200, at);
        check("term_edge_time", at - v, 100);
        check("term_edge_bin", int'(bin_a), 1);
        wait_valid(0, 200, at);
        check("term_edge_next_bin", int'(bin_a), 0);

        // Reset pulse at gate_cnt == 60
        half_a = 10; ph_a = 0;
        wait_valid(0, 200, v);
        wait_valid(0, 200, v);
        check("pre_reset_bin", int'(bin_a), 5);
        while (cyc < v + 60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_bin", int'(bin_a), 0);
        check("async_reset_valid", int'(valid_a), 0);
        check("async_reset_ovf", int'(ovf_a), 0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_valid(0, 200, at);
        check("post_reset_latency", at - rel, 103);
        check("post_reset_bin", int'(bin_a), 5);

        // sig_in held high through reset release
        @(negedge clk);
        rst_n = 1'b0;
        half_a = 0;
        sig_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        wait_valid(0, 200, at);
        check("high_thru_reset_latency", at - rel, 103);
        check("high_thru_reset_bin", int'(bin_a), 0);
        prev = at;
        wait_valid(0, 200, at);
        check("high_const_interval", at - prev, 100);
        check("high_const_bin", int'(bin_a), 0);

`ifdef FREQ_METER_HOLD_EN
        half_a = 10; ph_a = 0;
        wait_valid(0, 200, v);
        wait_valid(0, 200, v);
        check("hold_pre_bin", int'(bin_a), 5);
        half_a = 5; ph_a = 0;
        hold_a = 1'b1;
        while (cyc < v + 100) @(negedge clk);
        check("hold_valid_suppressed", int'(valid_a), 0);
        check("hold_bin_kept", int'(bin_a), 5);
        @(negedge clk);
        hold_a = 1'b0;
        wait_valid(0, 200, at);
        check("hold_release_time", at - v, 200);
        check("hold_release_bin", int'(bin_a), 10);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
